crc_stream_feeder: RTL and testbench
====================================

// Module: crc_stream_feeder
// PURPOSE
// - Bus-initiator end of the CRC data-register write interface: takes a byte count plus a 32-bit
//   source stream and issues sized writes (WORD/HALF_WORD/BYTE) into the CRC unit.
// - Obeys the CRC unit's buffer_full wait; optionally restarts the CRC chain first.
// - Waits until the CRC pipeline drains (read_wait low), then returns the CRC result.
// - Sits between a DMA/stream source and the CRC datapath; replaces CPU-driven programmed writes.
// PARAMETERS
// - LEN_W  16  width of byte-count input (max message 2^LEN_W-1 bytes)
// PORTS
// - clk             in   1      clock
// - rst_n           in   1      reset (see BEHAVIOUR)
// - start           in   1      begin job; sampled only in IDLE
// - restart         in   1      with start: clear CRC chain before first write
// - length          in   LEN_W  message length in bytes; sampled with start
// - src_valid       in   1      source word valid
// - src_ready       out  1      source word accepted when src_valid&&src_ready
// - src_data        in   32     source word, byte 0 in [7:0]
// - crc_write       out  1      write request to CRC unit
// - crc_size        out  2      00 BYTE, 01 HALF_WORD, 10 WORD
// - crc_wdata       out  32     write data, valid bytes LSB-aligned
// - crc_reset_chain out  1      one-cycle chain-reset pulse
// - crc_buffer_full in   1      CRC wait: write not accepted this cycle
// - crc_read_wait   in   1      CRC unit still processing bytes
// - crc_out         in   32     current CRC value
// - busy            out  1      job in progress (state != IDLE)
// - done            out  1      one-cycle pulse, result valid
// - crc_result      out  32     CRC captured at done; held until next done
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low. Reset: IDLE, all outputs 0, crc_size=00.
// - Write accepted on cycle with crc_write && !crc_buffer_full.
// - While buffer_full: crc_write, crc_size and crc_wdata held stable.
// - FSM states:
//   IDLE -start-> ARM.
//   ARM: stay while crc_read_wait; then pulse crc_reset_chain if restart was latched.
//        Go to DRAIN if length==0, else FETCH.
//   FETCH: src_ready=1. On source handshake, latch word; go to WRITE.
//   WRITE: crc_write=1. crc_size from remaining bytes rem: rem>=4 WORD; rem==2|3 HALF_WORD; rem==1 BYTE.
//        On accept: rem-=size bytes.
//        rem==0 -> DRAIN. rem>0 after a half-word from rem==3 -> TAIL (data >>16). Else -> FETCH.
//   TAIL: crc_write=1, BYTE, crc_wdata=latched[23:16]; on accept -> DRAIN.
//   DRAIN: skip first cycle (read_wait rises one cycle after accept).
//        Then wait crc_read_wait==0; capture crc_out into crc_result, pulse done -> IDLE.
// - Only one source word is held. src_ready=0 outside FETCH; no prefetch.
// - Tail word: unused upper bytes are ignored; source must still present the word.
// - start while busy: ignored. restart/length latched only at IDLE->ARM.
// - rem width LEN_W. rem never underflows: size is chosen from rem.
// - Reset mid-job: abort immediately; the pending write is dropped.
//   The CRC unit's state is not this block's concern.
// CONFIGURATION
// - CRC_FEEDER_BSWAP_EN defined: latched source word byte-reversed
//   (src_data[7:0]->[31:24], ...) before size slicing, for big-endian sources.
// - Undefined: word used as-is, byte 0 = [7:0].
// STRUCTURE
// - Shared crc package: size codes BYTE/HALF_WORD/WORD, feeder state localparams.
// - One sub-module: crc_feeder_slicer, combinational.
//   (rem, latched word) -> crc_size, crc_wdata, bytes consumed.
// TESTING
// - length=8, restart=1, words 0x04030201,0x08070605, no wait:
//   one reset_chain pulse in ARM; two WORD writes; done once with crc_result=crc_out.
// - length=7: writes WORD, HALF_WORD 0x0605 (from word [15:0]), BYTE 0x07 in TAIL; exactly 3 accepts.
// - buffer_full high 3 cycles during 2nd write: write/size/data stable 3 cycles; single accept.
// - length=0, start: no crc_write, no src_ready; done after read_wait low.
// - rst_n low mid-WRITE: outputs 0 asynchronously; after release, new start with length=1 gives one BYTE write.
// - CRC_FEEDER_BSWAP_EN, length=4, word 0x11223344: crc_wdata=0x44332211 WORD.

Source files
------------

// File: rtl/crc_stream_feeder_pkg.sv
// Shared definitions for the CRC stream feeder: write-size codes, FSM states and byte helpers.
package crc_stream_feeder_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE      = 2'b00,
    SIZE_HALF_WORD = 2'b01,
    SIZE_WORD      = 2'b10
  } crc_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_FETCH,
    ST_WRITE,
    ST_TAIL,
    ST_DRAIN
  } feeder_state_e;

  localparam int WORD_BYTES = 4;
  localparam int HALF_BYTES = 2;

  // Big-endian sources put their first byte in the top lane.
  function automatic logic [31:0] byte_swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/crc_feeder_slicer.sv
// Picks the CRC write size from the bytes still owed and aligns the matching bytes to the LSBs.
module crc_feeder_slicer
  import crc_stream_feeder_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic [LEN_W-1:0] i_rem,
  input  logic [31:0]      i_word,
  output crc_size_e        o_size,
  output logic [31:0]      o_wdata,
  output logic [2:0]       o_consumed
);

  // A three-byte remainder goes out as a half-word here; the top byte is finished by the tail write.
  always_comb begin
    o_size     = SIZE_BYTE;
    o_wdata    = '0;
    o_consumed = '0;
    if (i_rem >= LEN_W'(WORD_BYTES)) begin
      o_size     = SIZE_WORD;
      o_wdata    = i_word;
      o_consumed = 3'(WORD_BYTES);
    end else if (i_rem >= LEN_W'(HALF_BYTES)) begin
      o_size     = SIZE_HALF_WORD;
      o_wdata    = {16'h0000, i_word[15:0]};
      o_consumed = 3'(HALF_BYTES);
    end else if (i_rem == LEN_W'(1)) begin
      o_size     = SIZE_BYTE;
      o_wdata    = {24'h000000, i_word[7:0]};
      o_consumed = 3'd1;
    end
  end

endmodule

// File: rtl/crc_stream_feeder.sv
// Streams a byte-counted message into the CRC data register and returns the final CRC.
// Define CRC_FEEDER_BSWAP_EN to byte-reverse each source word for big-endian sources.
module crc_stream_feeder
  import crc_stream_feeder_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_restart,
  input  logic [LEN_W-1:0] i_length,
  input  logic             i_src_valid,
  output logic             o_src_ready,
  input  logic [31:0]      i_src_data,
  output logic             o_crc_write,
  output logic [1:0]       o_crc_size,
  output logic [31:0]      o_crc_wdata,
  output logic             o_crc_reset_chain,
  input  logic             i_crc_buffer_full,
  input  logic             i_crc_read_wait,
  input  logic [31:0]      i_crc_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [31:0]      o_crc_result
);

  feeder_state_e    r_state;
  feeder_state_e    w_next_state;
  logic [LEN_W-1:0] r_rem;
  logic [31:0]      r_word;
  logic             r_restart;
  logic             r_drain_armed;
  logic             r_done;
  logic [31:0]      r_result;

  logic [31:0]      w_src_word;
  crc_size_e        w_size;
  logic [31:0]      w_slice_data;
  logic [2:0]       w_consumed;
  logic [LEN_W-1:0] w_rem_after;

  always_comb begin
`ifdef CRC_FEEDER_BSWAP_EN
    w_src_word = byte_swap32(i_src_data);
`else
    w_src_word = i_src_data;
`endif
  end

  crc_feeder_slicer #(
    .LEN_W(LEN_W)
  ) u_slicer (
    .i_rem     (r_rem),
    .i_word    (r_word),
    .o_size    (w_size),
    .o_wdata   (w_slice_data),
    .o_consumed(w_consumed)
  );

  assign w_rem_after = r_rem - LEN_W'(w_consumed);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Write outputs come only from registered state, so they cannot move while the CRC unit stalls.
  always_comb begin
    w_next_state      = r_state;
    o_src_ready       = 1'b0;
    o_crc_write       = 1'b0;
    o_crc_size        = SIZE_BYTE;
    o_crc_wdata       = '0;
    o_crc_reset_chain = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = ST_ARM;
        end
      end
      ST_ARM: begin
        if (!i_crc_read_wait) begin
          o_crc_reset_chain = r_restart;
          w_next_state      = (r_rem == '0) ? ST_DRAIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        o_src_ready = 1'b1;
        if (i_src_valid) begin
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        o_crc_write = 1'b1;
        o_crc_size  = w_size;
        o_crc_wdata = w_slice_data;
        if (!i_crc_buffer_full) begin
          if (w_rem_after == '0) begin
            w_next_state = ST_DRAIN;
          end else if (r_rem == LEN_W'(3)) begin
            w_next_state = ST_TAIL;
          end else begin
            w_next_state = ST_FETCH;
          end
        end
      end
      ST_TAIL: begin
        o_crc_write = 1'b1;
        o_crc_size  = SIZE_BYTE;
        o_crc_wdata = {24'h000000, r_word[23:16]};
        if (!i_crc_buffer_full) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (r_drain_armed && !i_crc_read_wait) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // read_wait lags the last accept by a cycle, so the first DRAIN cycle is never trusted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem         <= '0;
      r_word        <= '0;
      r_restart     <= 1'b0;
      r_drain_armed <= 1'b0;
      r_done        <= 1'b0;
      r_result      <= '0;
    end else begin
      r_done        <= 1'b0;
      r_drain_armed <= (r_state == ST_DRAIN);
      if (r_state == ST_IDLE && i_start) begin
        r_rem     <= i_length;
        r_restart <= i_restart;
      end
      if (r_state == ST_FETCH && i_src_valid) begin
        r_word <= w_src_word;
      end
      if (r_state == ST_WRITE && !i_crc_buffer_full) begin
        r_rem <= w_rem_after;
      end
      if (r_state == ST_TAIL && !i_crc_buffer_full) begin
        r_rem <= '0;
      end
      if (r_state == ST_DRAIN && r_drain_armed && !i_crc_read_wait) begin
        r_result <= i_crc_out;
        r_done   <= 1'b1;
      end
    end
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_crc_result = r_result;

endmodule

// File: tb/tb_crc_stream_feeder.sv
// Self-checking bench for crc_stream_feeder: expected CRC writes come from a byte-stream model.
module tb_crc_stream_feeder;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start;
  logic             i_restart;
  logic [LEN_W-1:0] i_length;
  logic             i_src_valid;
  logic             o_src_ready;
  logic [31:0]      i_src_data;
  logic             o_crc_write;
  logic [1:0]       o_crc_size;
  logic [31:0]      o_crc_wdata;
  logic             o_crc_reset_chain;
  logic             i_crc_buffer_full;
  logic             i_crc_read_wait;
  logic [31:0]      i_crc_out;
  logic             o_busy;
  logic             o_done;
  logic [31:0]      o_crc_result;

  int          nAsserts = 0;
  int          nFails = 0;
  logic [31:0] jobWords[$];
  logic [31:0] firstWdata;
  logic [1:0]  firstSize;

  always #5 clk = ~clk;

  crc_stream_feeder #(.LEN_W(LEN_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_start          (i_start),
    .i_restart        (i_restart),
    .i_length         (i_length),
    .i_src_valid      (i_src_valid),
    .o_src_ready      (o_src_ready),
    .i_src_data       (i_src_data),
    .o_crc_write      (o_crc_write),
    .o_crc_size       (o_crc_size),
    .o_crc_wdata      (o_crc_wdata),
    .o_crc_reset_chain(o_crc_reset_chain),
    .i_crc_buffer_full(i_crc_buffer_full),
    .i_crc_read_wait  (i_crc_read_wait),
    .i_crc_out        (i_crc_out),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_crc_result     (o_crc_result)
  );

  // Runs one job; stallMode 0 = no stalls, 1 = random buffer_full, 2 = three stall cycles on the 2nd write.
  task automatic run_job(input int len, input bit restart, input int stallMode, input bit directed,
                         input string tag);
    int          nWords, wIdx, accIdx, rcCount, rwCnt, stallLeft, stallSeen, pos, k;
    byte unsigned msg[$];
    int          chunks[$];
    logic [1:0]  expSize[$];
    logic [31:0] expData[$];
    logic [31:0] d, lastCrc;
    bit          gotDone, prevStall;
    logic [1:0]  prevSize;
    logic [31:0] prevData;

    nWords = (len + 3) / 4;
    while (jobWords.size() < nWords) jobWords.push_back($urandom);

    for (int b = 0; b < len; b++) begin
      int j;
      j = b % 4;
`ifdef CRC_FEEDER_BSWAP_EN
      j = 3 - j;
`endif
      msg.push_back(8'(jobWords[b / 4] >> (8 * j)));
    end
    pos = 0;
    while (pos < len) begin
      k = (len - pos >= 4) ? 4 : len - pos;
      if (k == 3) begin
        chunks.push_back(2);
        chunks.push_back(1);
      end else begin
        chunks.push_back(k);
      end
      pos += k;
    end
    pos = 0;
    foreach (chunks[c]) begin
      d = '0;
      for (int i = 0; i < chunks[c]; i++) d = d | (32'(msg[pos + i]) << (8 * i));
      expData.push_back(d);
      expSize.push_back(chunks[c] == 4 ? 2'b10 : (chunks[c] == 2 ? 2'b01 : 2'b00));
      pos += chunks[c];
    end

    wIdx = 0; accIdx = 0; rcCount = 0; stallLeft = 3; stallSeen = 0;
    gotDone = 0; prevStall = 0; prevSize = '0; prevData = '0; lastCrc = '0;
    firstWdata = '0; firstSize = '0;

    @(negedge clk);
    i_start = 1'b1; i_restart = restart; i_length = LEN_W'(len);
    i_src_valid = 1'b0; i_crc_buffer_full = 1'b0; i_crc_read_wait = 1'b0;
    i_crc_out = $urandom;
    rwCnt = directed ? 0 : int'($urandom_range(0, 3));
    @(negedge clk);
    i_start = 1'b0;

    for (int cyc = 0; cyc < 3000 && !gotDone; cyc++) begin
      if (!directed) begin
        i_start   = ($urandom_range(0, 4) == 0);
        i_restart = 1'($urandom_range(0, 1));
        i_length  = LEN_W'($urandom);
      end
      i_src_valid = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
      i_src_data  = (wIdx < nWords) ? jobWords[wIdx] : $urandom;
      i_crc_read_wait = (rwCnt > 0);
      if (rwCnt > 0) begin
        rwCnt--;
        i_crc_out = $urandom;
      end
      case (stallMode)
        1:       i_crc_buffer_full = ($urandom_range(0, 2) == 0);
        2:       i_crc_buffer_full = o_crc_write && accIdx == 1 && stallLeft > 0;
        default: i_crc_buffer_full = 1'b0;
      endcase
      #1;
      if (prevStall) begin
        nAsserts++;
        if (o_crc_write !== 1'b1 || o_crc_size !== prevSize || o_crc_wdata !== prevData) begin
          nFails++;
          $display("[TB] FAIL %s stall_hold: write=%b size=%0d data=%h, expected write=1 size=%0d data=%h",
                   tag, o_crc_write, o_crc_size, o_crc_wdata, prevSize, prevData);
        end
      end
      if (o_src_ready === 1'b1 && o_crc_write === 1'b1) begin
        nAsserts++; nFails++;
        $display("[TB] FAIL %s ready_and_write: src_ready=1 crc_write=1, expected not both", tag);
      end
      if (o_crc_reset_chain === 1'b1) begin
        rcCount++;
        nAsserts++;
        if (wIdx != 0 || accIdx != 0) begin
          nFails++;
          $display("[TB] FAIL %s chain_order: pulse after %0d fetches, expected 0", tag, wIdx);
        end
      end
      if (o_src_ready === 1'b1 && i_src_valid) begin
        nAsserts++;
        if (wIdx >= nWords) begin
          nFails++;
          $display("[TB] FAIL %s extra_fetch: fetch %0d, expected at most %0d", tag, wIdx + 1, nWords);
        end
        wIdx++;
      end
      if (o_crc_write === 1'b1 && i_crc_buffer_full) begin
        stallSeen++;
        if (stallLeft > 0) stallLeft--;
      end
      if (o_crc_write === 1'b1 && !i_crc_buffer_full) begin
        nAsserts++;
        if (accIdx == 0) begin
          firstWdata = o_crc_wdata;
          firstSize  = o_crc_size;
        end
        if (accIdx >= expData.size()) begin
          nFails++;
          $display("[TB] FAIL %s extra_write: write %0d data=%h, expected %0d writes",
                   tag, accIdx, o_crc_wdata, expData.size());
        end else if (o_crc_size !== expSize[accIdx] || o_crc_wdata !== expData[accIdx]) begin
          nFails++;
          $display("[TB] FAIL %s write%0d: size=%0d data=%h, expected size=%0d data=%h",
                   tag, accIdx, o_crc_size, o_crc_wdata, expSize[accIdx], expData[accIdx]);
        end
        accIdx++;
        rwCnt = directed ? 0 : int'($urandom_range(1, 4));
        i_crc_out = $urandom;
      end
      prevStall = (o_crc_write === 1'b1) && i_crc_buffer_full;
      prevSize  = o_crc_size;
      prevData  = o_crc_wdata;
      if (o_done === 1'b1) begin
        gotDone = 1;
        i_start = 1'b0;
        lastCrc = i_crc_out;
        nAsserts++;
        if (o_crc_result !== i_crc_out) begin
          nFails++;
          $display("[TB] FAIL %s result: crc_result=%h, expected %h", tag, o_crc_result, i_crc_out);
        end
      end else begin
        nAsserts++;
        if (o_busy !== 1'b1) begin
          nFails++;
          $display("[TB] FAIL %s busy: busy=%b, expected 1", tag, o_busy);
        end
      end
      if (!gotDone) @(negedge clk);
    end

    nAsserts++;
    if (!gotDone) begin
      nFails++;
      $display("[TB] FAIL %s timeout: done=0, expected done within budget", tag);
    end
    nAsserts++;
    if (accIdx != expData.size()) begin
      nFails++;
      $display("[TB] FAIL %s write_count: %0d, expected %0d", tag, accIdx, expData.size());
    end
    nAsserts++;
    if (wIdx != nWords) begin
      nFails++;
      $display("[TB] FAIL %s fetch_count: %0d, expected %0d", tag, wIdx, nWords);
    end
    nAsserts++;
    if (rcCount != int'(restart)) begin
      nFails++;
      $display("[TB] FAIL %s chain_pulses: %0d, expected %0d", tag, rcCount, restart);
    end
    if (stallMode == 2) begin
      nAsserts++;
      if (stallSeen != 3) begin
        nFails++;
        $display("[TB] FAIL %s stall_cycles: %0d, expected 3", tag, stallSeen);
      end
    end
    @(negedge clk);
    i_start = 1'b0;
    i_crc_read_wait = 1'b0;
    i_crc_buffer_full = 1'b0;
    #1;
    nAsserts++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_crc_result !== lastCrc) begin
      nFails++;
      $display("[TB] FAIL %s after_done: done=%b busy=%b result=%h, expected 0 0 %h",
               tag, o_done, o_busy, o_crc_result, lastCrc);
    end
    jobWords.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_start = 1'b0; i_restart = 1'b0; i_length = '0; i_src_valid = 1'b0; i_src_data = '0;
    i_crc_buffer_full = 1'b0; i_crc_read_wait = 1'b0; i_crc_out = 32'hffff_ffff;
    #12;
    nAsserts++;
    if ({o_src_ready, o_crc_write, o_crc_size, o_crc_wdata, o_crc_reset_chain, o_busy, o_done,
         o_crc_result} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_state: ready=%b write=%b size=%0d wdata=%h chain=%b busy=%b done=%b result=%h, expected all 0",
               o_src_ready, o_crc_write, o_crc_size, o_crc_wdata, o_crc_reset_chain, o_busy, o_done,
               o_crc_result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_two_words();
    jobWords = {32'h0403_0201, 32'h0807_0605};
    run_job(8, 1'b1, 0, 1'b1, "len8_restart");
  endtask

  task automatic test_tail();
    jobWords = {32'h0403_0201, 32'h0807_0605};
    run_job(7, 1'b0, 0, 1'b1, "len7_tail");
  endtask

  task automatic test_stall();
    run_job(8, 1'b0, 2, 1'b1, "stall_2nd_write");
  endtask

  task automatic test_zero_length();
    run_job(0, 1'b1, 0, 1'b0, "len0");
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk);
    i_start = 1'b1; i_restart = 1'b0; i_length = LEN_W'(8);
    i_src_valid = 1'b1; i_src_data = 32'hdead_beef;
    i_crc_buffer_full = 1'b0; i_crc_read_wait = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    for (int c = 0; c < 20 && o_crc_write !== 1'b1; c++) @(negedge clk);
    nAsserts++;
    if (o_crc_write !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL mid_reset_reach: crc_write=%b, expected 1 before reset", o_crc_write);
    end
    i_crc_buffer_full = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    nAsserts++;
    if ({o_src_ready, o_crc_write, o_crc_size, o_crc_wdata, o_busy, o_done} !== '0) begin
      nFails++;
      $display("[TB] FAIL mid_reset_outputs: write=%b size=%0d wdata=%h busy=%b, expected all 0",
               o_crc_write, o_crc_size, o_crc_wdata, o_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_crc_buffer_full = 1'b0;
    i_src_valid = 1'b0;
    jobWords.delete();
    jobWords.push_back(32'h1234_56a5);
    run_job(1, 1'b0, 0, 1'b1, "len1_after_reset");
    nAsserts++;
    if (firstSize !== 2'b00 || firstWdata !== 32'h0000_00a5) begin
`ifndef CRC_FEEDER_BSWAP_EN
      nFails++;
      $display("[TB] FAIL len1_byte: size=%0d data=%h, expected size=0 data=000000a5", firstSize, firstWdata);
`endif
    end
  endtask

  task automatic test_bswap();
    logic [31:0] want;
`ifdef CRC_FEEDER_BSWAP_EN
    want = 32'h4433_2211;
`else
    want = 32'h1122_3344;
`endif
    jobWords = {32'h1122_3344};
    run_job(4, 1'b0, 0, 1'b1, "len4_word_order");
    nAsserts++;
    if (firstSize !== 2'b10 || firstWdata !== want) begin
      nFails++;
      $display("[TB] FAIL word_order: size=%0d data=%h, expected size=2 data=%h", firstSize, firstWdata, want);
    end
  endtask

  task automatic test_random_jobs();
    for (int n = 0; n < 14; n++) begin
      run_job(int'($urandom_range(0, 23)), 1'($urandom_range(0, 1)), 1, 1'b0, "random_job");
    end
    run_job(41, 1'b1, 1, 1'b0, "random_long");
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_tail();
    test_stall();
    test_zero_length();
    test_reset_mid_write();
    test_bswap();
    test_random_jobs();
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
